// File: rtl/samp_rate_pkg.sv
// samp_rate_pkg: rate indices, classification window bounds and FSM states
// shared by the sample-rate generator and detector.
package samp_rate_pkg;
    localparam logic [2:0] RATE_48K    = 3'd7;
    localparam logic [2:0] RATE_44K1   = 3'd6;
    localparam logic [2:0] RATE_32K    = 3'd5;
    localparam logic [2:0] RATE_24K    = 3'd4;
    localparam logic [2:0] RATE_22K05  = 3'd3;
    localparam logic [2:0] RATE_16K    = 3'd2;
    localparam logic [2:0] RATE_11K025 = 3'd1;
    localparam logic [2:0] RATE_8K     = 3'd0;
    // Inclusive half-period windows in 12 MHz cycles
    localparam int WIN_MIN       = 100;
    localparam int WIN_48K_MAX   = 130;
    localparam int WIN_44K1_MAX  = 162;
    localparam int WIN_32K_MAX   = 219;
    localparam int WIN_24K_MAX   = 261;
    localparam int WIN_22K05_MAX = 323;
    localparam int WIN_16K_MAX   = 459;
    localparam int WIN_11K_MAX   = 647;
    localparam int WIN_MAX       = 900;
    typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;
endpackage

// File: rtl/samp_rate_detector_if.sv
// samp_rate_detector_if: sample toggle input and rate-detection results.
interface samp_rate_detector_if #(parameter int CNT_W = 10);
    logic             samp_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic [2:0]       rate_code;
    logic [7:0]       rate_onehot;
    logic             rate_change;
    modport master (output samp_in, input half_period, meas_valid, locked, rate_code, rate_onehot, rate_change);
    modport slave  (input samp_in, output half_period, meas_valid, locked, rate_code, rate_onehot, rate_change);
endinterface

// File: rtl/samp_rate_classify.sv
// samp_rate_classify: maps a measured half-period to {valid, rate code}.
module samp_rate_classify import samp_rate_pkg::*; #(
    parameter int CNT_W = 10
) (
    input  logic [CNT_W-1:0] period,
    output logic             valid,
    output logic [2:0]       code
);
    logic [31:0] p;
    always_comb begin
        p = 32'(period);
        valid = (p >= WIN_MIN) && (p <= WIN_MAX);
        code = (p <= WIN_48K_MAX)   ? RATE_48K   :
               (p <= WIN_44K1_MAX)  ? RATE_44K1  :
               (p <= WIN_32K_MAX)   ? RATE_32K   :
               (p <= WIN_24K_MAX)   ? RATE_24K   :
               (p <= WIN_22K05_MAX) ? RATE_22K05 :
               (p <= WIN_16K_MAX)   ? RATE_16K   :
               (p <= WIN_11K_MAX)   ? RATE_11K025 : RATE_8K;
    end
endmodule

// File: rtl/samp_rate_detector.sv
// samp_rate_detector: measures the half-period of an incoming sample-rate
// toggle, classifies it and reports a locked rate code.
module samp_rate_detector import samp_rate_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10,
    parameter int LOCK_COUNT  = 4,
    parameter int MISS_LIMIT  = 2,
    parameter int TIMEOUT     = 1023
) (
    input logic                clock_in,
    input logic                reset_n,
    samp_rate_detector_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, half_period_q, half_period_d;
    logic                   meas_valid_q, meas_valid_d;
    state_e                 state_q, state_d;
    logic [2:0]             cand_q, cand_d, code_q, code_d, match_q, match_d;
    logic                   cand_ok_q, cand_ok_d, locked_q, locked_d;
    logic [1:0]             miss_q, miss_d;
    logic                   rate_change_q, rate_change_d;
    logic                   edge_p, timeout, cls_ok;
    logic [2:0]             cls_code;

    samp_rate_classify #(.CNT_W(CNT_W)) u_classify (.period(half_period_q), .valid(cls_ok), .code(cls_code));

    assign edge_p  = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign timeout = cnt_q == CNT_W'(TIMEOUT);

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.samp_in};
        prev_d        = sync_q[SYNC_STAGES-1];
        cnt_d         = edge_p ? CNT_W'(1) : timeout ? cnt_q : cnt_q + CNT_W'(1);
        meas_valid_d  = edge_p && (state_q != SEARCH);
        half_period_d = meas_valid_d ? cnt_q : half_period_q;
        state_d       = state_q;
        cand_d        = cand_q;
        cand_ok_d     = cand_ok_q;
        match_d       = match_q;
        miss_d        = miss_q;
        locked_d      = locked_q;
        code_d        = code_q;
        if (edge_p && state_q == SEARCH) begin
            state_d   = TRACK;
            cand_ok_d = 1'b0;
            match_d   = 3'd0;
        end else if (!edge_p && timeout && state_q != SEARCH) begin
            state_d   = SEARCH;
            cand_ok_d = 1'b0;
            match_d   = 3'd0;
            miss_d    = 2'd0;
            locked_d  = 1'b0;
            code_d    = 3'd0;
        end else if (meas_valid_q && state_q == TRACK) begin
            if (!cls_ok) begin
                cand_ok_d = 1'b0;
                match_d   = 3'd0;
            end else if (cand_ok_q && cls_code == cand_q) begin
                match_d = match_q + 3'd1;
            end else begin
                cand_d    = cls_code;
                cand_ok_d = 1'b1;
                match_d   = 3'd1;
            end
            if (match_d == 3'(LOCK_COUNT)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                code_d   = cand_d;
                miss_d   = 2'd0;
            end
        end else if (meas_valid_q && state_q == LOCKED) begin
            miss_d = (cls_ok && cls_code == code_q) ? 2'd0 : miss_q + 2'd1;
            // Losing lock seeds tracking with the class that broke it
            if (miss_d == 2'(MISS_LIMIT)) begin
                state_d   = TRACK;
                locked_d  = 1'b0;
                code_d    = 3'd0;
                miss_d    = 2'd0;
                cand_d    = cls_code;
                cand_ok_d = cls_ok;
                match_d   = cls_ok ? 3'd1 : 3'd0;
            end
        end
        rate_change_d = (locked_d != locked_q) || (code_d != code_q);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            half_period_q <= '0;
            meas_valid_q  <= 1'b0;
            state_q       <= SEARCH;
            cand_q        <= 3'd0;
            cand_ok_q     <= 1'b0;
            match_q       <= 3'd0;
            miss_q        <= 2'd0;
            locked_q      <= 1'b0;
            code_q        <= 3'd0;
            rate_change_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            meas_valid_q  <= meas_valid_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            cand_ok_q     <= cand_ok_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            locked_q      <= locked_d;
            code_q        <= code_d;
            rate_change_q <= rate_change_d;
        end
    end

    assign bus.half_period = half_period_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.locked      = locked_q;
    assign bus.rate_code   = code_q;
    assign bus.rate_onehot = locked_q ? 8'd1 << code_q : 8'd0;
    assign bus.rate_change = rate_change_q;
endmodule

// File: tb/tb_samp_rate_detector.sv
// tb_samp_rate_detector: directed and randomized toggle streams checked
// against a measurement-level lock model.
module tb_samp_rate_detector;
    localparam int LOCK_COUNT = 4;
    localparam int MISS_LIMIT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   since = 0;
    int   meas_at = 0;
    bit   m_search = 1'b1;
    bit   m_locked = 1'b0;
    int   m_code = 0;
    int   m_cand = -1;
    int   m_run = 0;
    int   m_miss = 0;
    int   lo[8] = '{648, 460, 324, 262, 220, 163, 131, 100};
    int   hi[8] = '{900, 647, 459, 323, 261, 219, 162, 130};

    samp_rate_detector_if #(.CNT_W(10)) bus ();

    samp_rate_detector #(.SYNC_STAGES(2), .CNT_W(10), .LOCK_COUNT(LOCK_COUNT),
                         .MISS_LIMIT(MISS_LIMIT), .TIMEOUT(1023))
        dut (.clock_in(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input int hp);
        for (int r = 0; r < 8; r++)
            if (hp >= lo[r] && hp <= hi[r]) return r;
        return -1;
    endfunction

    task automatic model_reset();
        m_search = 1'b1;
        m_locked = 1'b0;
        m_code = 0;
        m_cand = -1;
        m_run = 0;
        m_miss = 0;
    endtask

    task automatic model_meas(input int hp);
        int c;
        c = classify(hp);
        if (!m_locked) begin
            if (c < 0) begin
                m_cand = -1;
                m_run = 0;
            end else if (c == m_cand) m_run++;
            else begin
                m_cand = c;
                m_run = 1;
            end
            if (m_run == LOCK_COUNT) begin
                m_locked = 1'b1;
                m_code = c;
                m_miss = 0;
            end
        end else if (c == m_code) m_miss = 0;
        else begin
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
                m_locked = 1'b0;
                m_code = 0;
                m_cand = c;
                m_run = (c < 0) ? 0 : 1;
                m_miss = 0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_half_period"}, 32'(bus.half_period), 0);
        check({tag, "_meas_valid"}, 32'(bus.meas_valid), 0);
        check({tag, "_locked"}, 32'(bus.locked), 0);
        check({tag, "_rate_code"}, 32'(bus.rate_code), 0);
        check({tag, "_rate_onehot"}, 32'(bus.rate_onehot), 0);
        check({tag, "_rate_change"}, 32'(bus.rate_change), 0);
    endtask

    // Toggle samp_in g cycles after the previous toggle; the edge measures g
    task automatic toggle_after(input int g);
        bit seen;
        bit pl;
        int pc;
        while (since < g) begin
            @(negedge clk);
            since++;
        end
        bus.samp_in = ~bus.samp_in;
        since = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            since++;
            seen = bus.meas_valid;
        end
        check("meas_valid", 32'(seen), 32'(!m_search));
        if (m_search) begin
            m_search = 1'b0;
            m_cand = -1;
            m_run = 0;
        end else begin
            meas_at = since;
            check("half_period", 32'(bus.half_period), g);
            pl = m_locked;
            pc = m_code;
            model_meas(g);
            @(negedge clk);
            since++;
            check("locked", 32'(bus.locked), 32'(m_locked));
            check("rate_code", 32'(bus.rate_code), m_code);
            check("rate_onehot", 32'(bus.rate_onehot), m_locked ? (1 << m_code) : 0);
            check("rate_change", 32'(bus.rate_change), 32'((pl != m_locked) || (pc != m_code)));
        end
    endtask

    initial begin
        int start;
        int r;
        int n;
        int g;
        int bvals[4] = '{100, 130, 131, 900};
        int bcodes[4] = '{7, 7, 6, 0};
        bus.samp_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        since = 2000;
        repeat (6) toggle_after(125);
        check("lock48_code", 32'(bus.rate_code), 7);
        check("lock48_onehot", 32'(bus.rate_onehot), 32'h80);
        toggle_after(60);
        check("glitch_hold", 32'(bus.locked), 1);
        repeat (2) toggle_after(125);
        repeat (7) toggle_after(375);
        check("switch_code", 32'(bus.rate_code), 2);
        for (int i = 0; i < 10; i++) toggle_after((i % 2 == 0) ? 187 : 188);
        check("lock32_code", 32'(bus.rate_code), 5);
        start = meas_at;
        while (bus.locked && since - start < 1100) begin
            @(negedge clk);
            since++;
        end
        check("timeout_cycles", since - start, 1023);
        check("timeout_code", 32'(bus.rate_code), 0);
        check("timeout_change", 32'(bus.rate_change), 1);
        model_reset();
        repeat (6) toggle_after(125);
        check("relock_code", 32'(bus.rate_code), 7);
        #2;
        reset_n = 1'b0;
        bus.samp_in = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        since = 2000;
        repeat (3) @(negedge clk);
        check("post_reset_change", 32'(bus.rate_change), 0);
        toggle_after(125);
        for (int i = 0; i < LOCK_COUNT - 1; i++) toggle_after(125);
        check("reset_not_yet", 32'(bus.locked), 0);
        toggle_after(125);
        check("reset_relock", 32'(bus.locked), 1);
        for (int b = 0; b < 4; b++) begin
            repeat (8) toggle_after(bvals[b]);
            check("bound_locked", 32'(bus.locked), 1);
            check("bound_code", 32'(bus.rate_code), bcodes[b]);
        end
        repeat (10) toggle_after(99);
        check("bound_99", 32'(bus.locked), 0);
        repeat (10) toggle_after(901);
        check("bound_901", 32'(bus.locked), 0);
        for (int b = 0; b < 20; b++) begin
            r = $urandom_range(7);
            n = $urandom_range(7, 1);
            for (int k = 0; k < n; k++) begin
                g = ($urandom_range(7) == 0) ? $urandom_range(1000, 60) : $urandom_range(hi[r], lo[r]);
                toggle_after(g);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
